bus_ram_responder: RTL

BUS_RAM_RESPONDER -- requirements
Module: bus_ram_responder

---
 rtl/bus_ram_responder.sv | 138 +++++++++++++
 1 files changed

// File: rtl/bus_ram_responder.sv
// Single-port word RAM behind a simple request/ack bus with a fixed number of wait states.
// o_dbg_state exposes the FSM state: 0 = IDLE, 1 = WAIT, 2 = ACK.
module bus_ram_responder #(
    parameter int          MEM_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          LATENCY   = 1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_bus_en,
    input  logic        i_wr_en,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wr_data,
    input  logic [3:0]  i_byte_en,
    output logic        o_ack,
    output logic [31:0] o_rd_data,
    output logic [1:0]  o_dbg_state
);

    localparam int AW = $clog2(MEM_WORDS);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_ACK  = 2'd2;

    localparam logic [3:0] CNT_LOAD = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    // Handshake: the master raises i_bus_en with the request fields and holds
    // them until o_ack; o_ack is a single-cycle pulse, and i_bus_en is only
    // looked at in IDLE, so a request held past o_ack is taken as a new one.

    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        wr_q;
    logic [29:0] addr_q;
    logic [31:0] data_q;
    logic [3:0]  be_q;
    logic [31:0] rd_data_q;

    logic        go;
    logic        use_live;
    logic        acc_wr;
    logic [29:0] acc_word;
    logic [31:0] acc_data;
    logic [3:0]  acc_be;
    logic [29:0] word_ofs;
    logic        in_range;
    logic [AW-1:0] idx;
    logic        unused_addr_lsb;

    logic [31:0] mem_q [MEM_WORDS];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        go      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (i_bus_en) begin
                    if (LATENCY == 0) begin
                        state_d = S_ACK;
                        go      = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = CNT_LOAD;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_ACK;
                    go      = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_ACK:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // With zero wait states the RAM is accessed on the accepting edge itself,
    // so the live bus fields are used instead of the latched copies.
    assign use_live = (state_q == S_IDLE);
    assign acc_wr   = use_live ? i_wr_en         : wr_q;
    assign acc_word = use_live ? i_addr[31:2]    : addr_q;
    assign acc_data = use_live ? i_wr_data       : data_q;
    assign acc_be   = use_live ? i_byte_en       : be_q;

    assign word_ofs = acc_word - BASE_ADDR[31:2];
    assign in_range = ({2'b00, word_ofs} < 32'(MEM_WORDS));
    assign idx      = word_ofs[AW-1:0];

    assign unused_addr_lsb = ^i_addr[1:0];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (state_q == S_IDLE && i_bus_en) begin
            wr_q   <= i_wr_en;
            addr_q <= i_addr[31:2];
            data_q <= i_wr_data;
            be_q   <= i_byte_en;
        end
    end

    // Storage is not reset; a reset on the commit edge suppresses the write.
    always_ff @(posedge i_clk) begin
        if (!i_rst && go && acc_wr && in_range) begin
            for (int b = 0; b < 4; b++) begin
                if (acc_be[b]) begin
                    mem_q[idx][8*b +: 8] <= acc_data[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rd_data_q <= 32'h0;
        end else if (go && !acc_wr) begin
            rd_data_q <= in_range ? mem_q[idx] : 32'h0;
        end
    end

    assign o_ack       = (state_q == S_ACK);
    assign o_rd_data   = rd_data_q;
    assign o_dbg_state = state_q;

endmodule
